// File: rtl/hamming_dec_engine.sv
// Hamming(15,11) single-error-correcting decoder engine.
// On each request it walks NUM_MSG codewords held as byte pairs in data memory,
// corrects at most one flipped bit per codeword and writes the 11 recovered data
// bits back as byte pairs. err_cnt reports how many codewords needed a correction.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for req; idx and err_cnt are cleared on the start edge
// RD_LO | drive input low-byte address, capture codeword[8:1]
// RD_HI | drive input high-byte address, capture codeword[15:9]
// CORR  | syndrome, single-bit correction, data extraction, err_cnt update
// WR_LO | write d[8:1] to the output low byte
// WR_HI | write {5'b0, d[11:9]}; advance idx or finish the run
// DONE  | one-cycle ack, then back to IDLE
module hamming_dec_engine #(
    parameter int NUM_MSG  = 15,
    parameter int IN_BASE  = 64,
    parameter int OUT_BASE = 94,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    input  logic [7:0]        mem_rd_data,
    output logic [3:0]        err_cnt
);

    localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

    // Codeword positions carrying data, in order d1..d11.
    localparam logic [3:0] DATA_POS [11] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10,
                                              4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        CORR  = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        lo_q;
    logic [6:0]        hi_q;
    logic [10:0]       data_q;
    logic [15:1]       cw;
    logic [3:0]        syn;
    logic [10:0]       corr_data;
    logic              last_msg;
    logic [ADDR_W-1:0] idx_ofs;
    logic [ADDR_W-1:0] in_addr;
    logic [ADDR_W-1:0] out_addr;

    assign cw       = {hi_q, lo_q};
    assign last_msg = (idx_q == IDX_W'(NUM_MSG - 1));
    assign idx_ofs  = ADDR_W'({idx_q, 1'b0});
    assign in_addr  = ADDR_W'(IN_BASE) + idx_ofs;
    assign out_addr = ADDR_W'(OUT_BASE) + idx_ofs;

    // Syndrome is the XOR of the indices of all set positions; a nonzero value
    // names the single position to invert. Only data positions are rebuilt, so
    // a flipped parity bit simply drops out.
    always_comb begin
        syn = '0;
        for (int p = 1; p <= 15; p++) begin
            if (cw[p]) syn = syn ^ 4'(p);
        end
        corr_data = '0;
        for (int k = 0; k < 11; k++) begin
            corr_data[k] = cw[DATA_POS[k]] ^ (syn == DATA_POS[k]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and memory-port decode.
    always_comb begin
        state_d     = state_q;
        ack         = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state_q)
            IDLE:  if (req) state_d = RD_LO;
            RD_LO: begin
                mem_addr = in_addr;
                state_d  = RD_HI;
            end
            RD_HI: begin
                mem_addr = in_addr + ADDR_W'(1);
                state_d  = CORR;
            end
            CORR:  state_d = WR_LO;
            WR_LO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = out_addr;
                mem_wr_data = data_q[7:0];
                state_d     = WR_HI;
            end
            WR_HI: begin
                mem_wr_en   = 1'b1;
                mem_addr    = out_addr + ADDR_W'(1);
                mem_wr_data = {5'b0, data_q[10:8]};
                state_d     = last_msg ? DONE : RD_LO;
            end
            DONE: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: message index, captured bytes, corrected data and error count.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            err_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        idx_q   <= '0;
                        err_cnt <= '0;
                    end
                end
                RD_LO: lo_q <= mem_rd_data;
                RD_HI: hi_q <= mem_rd_data[6:0];
                CORR: begin
                    data_q <= corr_data;
                    if (syn != 4'd0 && err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
                end
                WR_HI: if (!last_msg) idx_q <= idx_q + IDX_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Bench for hamming_dec_engine: byte memory model, directed vector table,
// hand-written multi-cycle sequences and randomized runs against a
// behavioural Hamming(15,11) model.
module tb_hamming_dec_engine;

    localparam int NUM_MSG  = 15;
    localparam int IN_BASE  = 64;
    localparam int OUT_BASE = 94;
    localparam int ADDR_W   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic              ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic [7:0]        mem_rd_data;
    logic [3:0]        err_cnt;

    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = '0;
    logic [7:0] tb_data = '0;
    int         wr_cnt = 0;
    int         ack_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] in_lo  [NUM_MSG];
    logic [7:0] in_hi  [NUM_MSG];
    logic [7:0] exp_lo [NUM_MSG];
    logic [7:0] exp_hi [NUM_MSG];
    int         exp_err;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] exp_lo;
        logic [7:0] exp_hi;
        int         err;
    } vec_t;

    vec_t tbl [$];

    hamming_dec_engine #(
        .NUM_MSG (NUM_MSG),
        .IN_BASE (IN_BASE),
        .OUT_BASE(OUT_BASE),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ack        (ack),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    // Single writer for the memory: bench loads when tb_we, otherwise the DUT.
    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_addr] = tb_data;
        end else if (mem_wr_en) begin
            mem[mem_addr] = mem_wr_data;
            wr_cnt++;
        end
        if (ack) ack_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: codeword bit p-1 holds position p.
    function automatic logic [14:0] encode(input logic [10:0] d);
        logic [14:0] c;
        int          k;
        logic        par;
        c = '0;
        k = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            par = 1'b0;
            for (int p = 1; p <= 15; p++) if ((p & (1 << j)) != 0) par ^= c[p-1];
            c[(1 << j) - 1] = par;
        end
        return c;
    endfunction

    function automatic logic [10:0] model_decode(input logic [14:0] c, output int had_err);
        int          s;
        int          k;
        logic [10:0] d;
        s = 0;
        for (int p = 1; p <= 15; p++) if (c[p-1]) s = s ^ p;
        had_err = (s != 0) ? 1 : 0;
        if (s != 0) c[s-1] = ~c[s-1];
        d = '0;
        k = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = c[p-1];
                k++;
            end
        end
        return d;
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    // Place inputs in memory and poison the output area.
    task automatic load();
        for (int i = 0; i < NUM_MSG; i++) begin
            poke(8'(IN_BASE + 2 * i), in_lo[i]);
            poke(8'(IN_BASE + 2 * i + 1), in_hi[i]);
            poke(8'(OUT_BASE + 2 * i), 8'hAA);
            poke(8'(OUT_BASE + 2 * i + 1), 8'hAA);
        end
    endtask

    task automatic set_all(input logic [7:0] lo, input logic [7:0] hi,
                           input logic [7:0] elo, input logic [7:0] ehi);
        for (int i = 0; i < NUM_MSG; i++) begin
            in_lo[i]  = lo;
            in_hi[i]  = hi;
            exp_lo[i] = elo;
            exp_hi[i] = ehi;
        end
        exp_err = 0;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < NUM_MSG; i++) begin
            check($sformatf("%s out_lo[%0d]", tag, i), int'(mem[8'(OUT_BASE + 2 * i)]), int'(exp_lo[i]));
            check($sformatf("%s out_hi[%0d]", tag, i), int'(mem[8'(OUT_BASE + 2 * i + 1)]), int'(exp_hi[i]));
        end
    endtask

    // Start one run from IDLE and check latency, ack width, err_cnt and outputs.
    task automatic run_check(input string tag);
        int n;
        int w0;
        int a0;
        w0  = wr_cnt;
        a0  = ack_cnt;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n   = 0;
        while (!ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ack latency"}, n, 75);
        check({tag, " err_cnt"}, int'(err_cnt), exp_err);
        @(negedge clk);
        check({tag, " ack width"}, int'(ack), 0);
        check({tag, " write count"}, wr_cnt - w0, 2 * NUM_MSG);
        check({tag, " ack count"}, ack_cnt - a0, 1);
        check_outputs(tag);
    endtask

    task automatic fill_random();
        logic [14:0] c;
        logic [10:0] d;
        int          mode;
        int          p1;
        int          p2;
        int          e;
        exp_err = 0;
        for (int i = 0; i < NUM_MSG; i++) begin
            d    = 11'($urandom_range(0, 2047));
            c    = encode(d);
            mode = $urandom_range(0, 3);
            p1   = $urandom_range(0, 14);
            p2   = (p1 + $urandom_range(1, 14)) % 15;
            if (mode != 0) c[p1] = ~c[p1];
            if (mode == 3) c[p2] = ~c[p2];
            in_lo[i]  = c[7:0];
            in_hi[i]  = {1'($urandom_range(0, 1)), c[14:8]};
            d         = model_decode(c, e);
            exp_lo[i] = d[7:0];
            exp_hi[i] = {5'b0, d[10:8]};
            exp_err  += e;
        end
        if (exp_err > 15) exp_err = 15;
    endtask

    initial begin
        logic [14:0] c;
        int          w0;
        int          a0;
        int          n;
        int          saw_wr;
        int          j;
        vec_t        v;

        // Directed per-message vectors: {lo, hi, expected lo, expected hi, corrected}.
        tbl.push_back('{8'hFF, 8'h7F, 8'hFF, 8'h07, 0});
        tbl.push_back('{8'h00, 8'h00, 8'h00, 8'h00, 0});
        tbl.push_back('{8'h03, 8'h00, 8'h01, 8'h00, 1});
        tbl.push_back('{8'hFF, 8'hFF, 8'hFF, 8'h07, 0});
        tbl.push_back('{8'h8B, 8'h40, 8'h00, 8'h04, 0});
        tbl.push_back('{8'h0B, 8'h40, 8'h00, 8'h04, 1});
        tbl.push_back('{8'hFF, 8'h3F, 8'hFF, 8'h07, 1});
        for (int k = 0; k < 15; k++) begin
            c = 15'(1) << k;
            tbl.push_back('{c[7:0], {1'b0, c[14:8]}, 8'h00, 8'h00, 1});
        end

        reset = 1'b1;
        req   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ack", int'(ack), 0);
        check("reset mem_wr_en", int'(mem_wr_en), 0);
        check("reset mem_addr", int'(mem_addr), 0);
        check("reset mem_wr_data", int'(mem_wr_data), 0);
        check("reset err_cnt", int'(err_cnt), 0);
        reset = 1'b0;
        @(negedge clk);

        // Clean all-ones, clean all-zero, every single-error position.
        set_all(8'hFF, 8'h7F, 8'hFF, 8'h07);
        load();
        run_check("clean_ones");
        set_all(8'h00, 8'h00, 8'h00, 8'h00);
        load();
        run_check("clean_zero");
        for (int k = 0; k < NUM_MSG; k++) begin
            c        = 15'(1) << k;
            in_lo[k] = c[7:0];
            in_hi[k] = {1'b0, c[14:8]};
        end
        exp_err = 15;
        load();
        run_check("every_pos");

        // Vector table, in batches of NUM_MSG; tail padded with model-checked randoms.
        for (int b = 0; b * NUM_MSG < tbl.size(); b++) begin
            fill_random();
            exp_err = 0;
            for (int i = 0; i < NUM_MSG; i++) begin
                j = b * NUM_MSG + i;
                if (j < tbl.size()) begin
                    v         = tbl[j];
                    in_lo[i]  = v.lo;
                    in_hi[i]  = v.hi;
                    exp_lo[i] = v.exp_lo;
                    exp_hi[i] = v.exp_hi;
                    exp_err  += v.err;
                end else begin
                    c        = {in_hi[i][6:0], in_lo[i]};
                    void'(model_decode(c, n));
                    exp_err += n;
                end
            end
            if (exp_err > 15) exp_err = 15;
            load();
            run_check($sformatf("table%0d", b));
        end

        // Randomized runs.
        for (int r = 0; r < 4; r++) begin
            fill_random();
            load();
            run_check($sformatf("rand%0d", r));
        end

        // Reset 20 cycles into a run: no further writes and no ack.
        set_all(8'hFF, 8'h7F, 8'hFF, 8'h07);
        load();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset mem_addr", int'(mem_addr), 0);
        check("midreset err_cnt", int'(err_cnt), 0);
        w0     = wr_cnt;
        a0     = ack_cnt;
        saw_wr = 0;
        repeat (100) begin
            @(negedge clk);
            if (mem_wr_en) saw_wr = 1;
        end
        check("midreset wr_en seen", saw_wr, 0);
        check("midreset writes", wr_cnt - w0, 0);
        check("midreset acks", ack_cnt - a0, 0);
        load();
        run_check("after_reset");

        // reset and req on the same edge: reset wins.
        reset = 1'b1;
        req   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 1'b0;
        w0    = wr_cnt;
        a0    = ack_cnt;
        check("reset_req mem_addr", int'(mem_addr), 0);
        repeat (90) @(negedge clk);
        check("reset_req writes", wr_cnt - w0, 0);
        check("reset_req acks", ack_cnt - a0, 0);

        // Busy req: held 10 cycles and re-pulsed at cycle 40, errored inputs.
        for (int k = 0; k < NUM_MSG; k++) begin
            c         = 15'(1) << k;
            in_lo[k]  = c[7:0];
            in_hi[k]  = {1'b0, c[14:8]};
            exp_lo[k] = 8'h00;
            exp_hi[k] = 8'h00;
        end
        exp_err = 15;
        load();
        w0  = wr_cnt;
        a0  = ack_cnt;
        req = 1'b1;
        @(negedge clk);
        n = 0;
        while (!ack && n < 200) begin
            req = (n < 9) || (n == 39);
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        check("busy ack latency", n, 75);
        check("busy err_cnt", int'(err_cnt), 15);
        repeat (20) @(negedge clk);
        check("busy acks", ack_cnt - a0, 1);
        check("busy writes", wr_cnt - w0, 2 * NUM_MSG);
        check_outputs("busy");
        set_all(8'hFF, 8'hFF, 8'hFF, 8'h07);
        load();
        run_check("second_req");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
